// File: rtl/cic_comp_fir_pkg.sv
// ---------------------------------------------------------------------------
// cic_pkg
// Shared constants and types for the CIC compensation FIR.
//   CIC_COMP_COEFS : the 8 unique taps of the 16-tap symmetric filter, Q1.14.
//                    The full (mirrored) filter sums to 16384, so DC gain is 1.
//   COEF_FRAC      : number of fractional coefficient bits.
//   s_sample_t     : signed sample at the default width.
//   s_acc_t        : signed accumulator at the default width.
//   state_t        : sequencing FSM states.
// ---------------------------------------------------------------------------
package cic_pkg;

   localparam int CIC_TAPS  = 16;
   localparam int CIC_HALF  = CIC_TAPS / 2;
   localparam int COEF_FRAC = 14;
   localparam int SAMPLE_W  = 12;
   localparam int COEF_W    = 16;
   localparam int ACC_W     = SAMPLE_W + 1 + COEF_W + $clog2(CIC_HALF);

   typedef logic signed [SAMPLE_W-1:0] s_sample_t;
   typedef logic signed [ACC_W-1:0]    s_acc_t;
   typedef logic signed [COEF_W-1:0]   s_coef_t;

   // Outer taps first; the last entry sits next to the filter centre.
   // Inverse-sinc shape: small alternating skirt, large centre pair.
   localparam s_coef_t CIC_COMP_COEFS [CIC_HALF] = '{
      -16'sd120, 16'sd180, -16'sd300, 16'sd420,
      -16'sd650, 16'sd1100, 16'sd2600, 16'sd4962
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MAC,
      ST_ROUND,
      ST_OUT
   } state_t;

   // Taps beyond the table read as zero so a longer TAPS still elaborates.
   function automatic s_coef_t cic_coef(input int k);
      s_coef_t c;
      c = '0;
      for (int i = 0; i < CIC_HALF; i++) begin
         if (i == k) c = CIC_COMP_COEFS[i];
      end
      return c;
   endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// ---------------------------------------------------------------------------
// cic_comp_fir_if
// Sample-side signals of the CIC compensation FIR.
//   data_in    : decimated sample from the CIC (driven by master)
//   data_clk   : level-shaped decimated-rate strobe (driven by master)
//   data_out   : compensated sample (driven by slave)
//   data_valid : one-cycle pulse per new data_out (driven by slave)
//   busy       : filter is sequencing (driven by slave)
//   overrun    : sticky dropped-sample flag (driven by slave)
// ---------------------------------------------------------------------------
interface cic_comp_fir_if #(
   parameter int DATA_WIDTH = 12
) ();

   logic signed [DATA_WIDTH-1:0] data_in;
   logic                         data_clk;
   logic signed [DATA_WIDTH-1:0] data_out;
   logic                         data_valid;
   logic                         busy;
   logic                         overrun;

   modport master (
      output data_in,
      output data_clk,
      input  data_out,
      input  data_valid,
      input  busy,
      input  overrun
   );

   modport slave (
      input  data_in,
      input  data_clk,
      output data_out,
      output data_valid,
      output busy,
      output overrun
   );

endinterface

// File: rtl/cic_comp_mac.sv
// ---------------------------------------------------------------------------
// cic_comp_mac
// Symmetric-FIR pre-add / multiply / accumulate step.
//   clk, reset : clock, async active-high reset
//   clear      : zero the accumulator (takes priority over en)
//   en         : acc += coef * (a + b)
//   a, b       : mirrored delay-line samples
//   coef       : Q1.14 tap
//   acc        : running accumulator
// ---------------------------------------------------------------------------
module cic_comp_mac #(
   parameter int DATA_WIDTH = 12,
   parameter int COEF_WIDTH = 16,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   input  logic signed [COEF_WIDTH-1:0] coef,
   output logic signed [ACC_WIDTH-1:0]  acc
);

   localparam int PRE_W  = DATA_WIDTH + 1;
   localparam int PROD_W = PRE_W + COEF_WIDTH;

   logic signed [PRE_W-1:0]     pre_add;
   logic signed [PROD_W-1:0]    prod;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;

   // Operands are sign-extended to the product width before multiplying.
   assign pre_add = PRE_W'(a) + PRE_W'(b);
   assign prod    = PROD_W'(pre_add) * PROD_W'(coef);

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_WIDTH'(prod);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/cic_comp_fir.sv
// ---------------------------------------------------------------------------
// cic_comp_fir
// Symmetric compensation FIR behind a CIC decimator. One sample is accepted
// per rising edge of data_clk, pushed into a circular delay line and filtered
// with TAPS/2 pre-add MAC steps; the rounded result appears on data_out with
// a one-cycle data_valid pulse 3+TAPS/2 cycles after the edge is detected.
//   clk, reset : clock, async active-high reset
//   fir        : cic_comp_fir_if.slave (data_in, data_clk, data_out,
//                data_valid, busy, overrun)
// Build option: CIC_COMP_SATURATE_EN clamps the rounded result to the output
// range; without it the result wraps to the DATA_WIDTH LSBs.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a data_clk rising edge
// LOAD     | write captured sample, advance wr_ptr, clear accumulator
// MAC      | one symmetric tap pair per cycle, TAPS/2 cycles
// ROUND    | round-half-up by 2^13, shift, clamp or wrap
// OUT      | present result and pulse data_valid
// ---------------------------------------------------------------------------
module cic_comp_fir
   import cic_pkg::*;
#(
   parameter int DATA_WIDTH = 12,
   parameter int TAPS       = 16,
   parameter int COEF_WIDTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   cic_comp_fir_if.slave fir
);

   localparam int HALF  = TAPS / 2;
   localparam int PTR_W = $clog2(TAPS);
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int ACC_W = DATA_WIDTH + 1 + COEF_WIDTH + $clog2(HALF);

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (COEF_FRAC - 1));

   state_t                       state_q, state_d;
   logic                         data_clk_q;
   logic                         clk_edge;
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]             tap_cnt_q, tap_cnt_d;
   logic signed [DATA_WIDTH-1:0] sample_q, sample_d;
   logic signed [DATA_WIDTH-1:0] result_q, result_d;
   logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                         data_valid_q, data_valid_d;
   logic                         overrun_q, overrun_d;
   logic signed [DATA_WIDTH-1:0] dline_q [TAPS];
   logic signed [DATA_WIDTH-1:0] dline_d [TAPS];
   logic signed [DATA_WIDTH-1:0] round_val;
   logic                         mac_clear, mac_en;
   logic [PTR_W-1:0]             idx_new, idx_old;
   logic signed [COEF_WIDTH-1:0] coef;
   logic signed [ACC_W-1:0]      mac_acc;

   assign clk_edge = fir.data_clk & ~data_clk_q;

   // wr_ptr points at the oldest entry once LOAD has advanced it, so
   // x[n-k] sits k+1 behind it and its mirror x[n-(TAPS-1-k)] sits k ahead.
   always_comb begin
      idx_new = PTR_W'((int'(wr_ptr_q) + TAPS - 1 - int'(tap_cnt_q)) % TAPS);
      idx_old = PTR_W'((int'(wr_ptr_q) + int'(tap_cnt_q)) % TAPS);
   end

   assign coef = cic_coef(int'(tap_cnt_q));

   cic_comp_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .ACC_WIDTH  (ACC_W)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clear (mac_clear),
      .en    (mac_en),
      .a     (dline_q[idx_new]),
      .b     (dline_q[idx_old]),
      .coef  (coef),
      .acc   (mac_acc)
   );

`ifdef CIC_COMP_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_WIDTH - 1)));

   logic signed [ACC_W-1:0] shifted;

   always_comb begin
      shifted = (mac_acc + RND_HALF) >>> COEF_FRAC;
      if (shifted > SAT_MAX) begin
         round_val = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         round_val = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         round_val = shifted[DATA_WIDTH-1:0];
      end
   end
`else
   assign round_val = DATA_WIDTH'((mac_acc + RND_HALF) >>> COEF_FRAC);
`endif

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      tap_cnt_d    = tap_cnt_q;
      sample_d     = sample_q;
      result_d     = result_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      dline_d      = dline_q;
      mac_clear    = 1'b0;
      mac_en       = 1'b0;
      // Any edge outside IDLE is dropped, including one landing on OUT->IDLE.
      overrun_d    = overrun_q | (clk_edge & (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            if (clk_edge) begin
               sample_d = fir.data_in;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            dline_d[wr_ptr_q] = sample_q;
            wr_ptr_d  = (wr_ptr_q == PTR_W'(TAPS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            tap_cnt_d = '0;
            mac_clear = 1'b1;
            state_d   = ST_MAC;
         end
         ST_MAC: begin
            mac_en = 1'b1;
            if (tap_cnt_q == CNT_W'(HALF - 1)) begin
               state_d = ST_ROUND;
            end else begin
               tap_cnt_d = tap_cnt_q + CNT_W'(1);
            end
         end
         ST_ROUND: begin
            result_d = round_val;
            state_d  = ST_OUT;
         end
         ST_OUT: begin
            data_out_d   = result_q;
            data_valid_d = 1'b1;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         data_clk_q   <= 1'b0;
         wr_ptr_q     <= '0;
         tap_cnt_q    <= '0;
         sample_q     <= '0;
         result_q     <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            dline_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         data_clk_q   <= fir.data_clk;
         wr_ptr_q     <= wr_ptr_d;
         tap_cnt_q    <= tap_cnt_d;
         sample_q     <= sample_d;
         result_q     <= result_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         overrun_q    <= overrun_d;
         dline_q      <= dline_d;
      end
   end

   assign fir.data_out   = data_out_q;
   assign fir.data_valid = data_valid_q;
   assign fir.busy       = (state_q != ST_IDLE);
   assign fir.overrun    = overrun_q;

endmodule

// File: doc/cic_comp_fir.md
CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 12, giving the input and output sample width.
REQ-002 The block SHALL have parameter TAPS, default 16, giving the symmetric FIR length; legal values are even and at least 4.
REQ-003 The block SHALL have parameter COEF_WIDTH, default 16, giving the signed coefficient width (Q1.14).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port data_in, input, DATA_WIDTH bits, signed: the decimated sample from the upstream CIC.
REQ-007 Port data_clk, input, 1 bit: the upstream decimated-rate strobe; it is level-shaped and synchronous to clk.
REQ-008 Port data_out, output, DATA_WIDTH bits, signed: the compensated sample.
REQ-009 Port data_valid, output, 1 bit: a one-cycle pulse marking a new data_out.
REQ-010 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 Port overrun, output, 1 bit: sticky flag for a dropped input sample.

Function
REQ-012 The block SHALL register data_clk and detect its rising edge as data_clk & ~data_clk_q.
REQ-013 The block SHALL run an FSM with states IDLE -> LOAD -> MAC -> ROUND -> OUT -> IDLE.
- IDLE -> LOAD on a detected edge.
- LOAD -> MAC unconditionally.
- MAC -> ROUND when tap_cnt == TAPS/2-1.
- ROUND -> OUT unconditionally.
- OUT -> IDLE unconditionally.
REQ-014 In LOAD, data_in as sampled at the edge-detect cycle SHALL be written into a TAPS-entry circular delay line at wr_ptr, and wr_ptr SHALL increment, wrapping from TAPS-1 to 0.
REQ-015 MAC SHALL take TAPS/2 cycles, one per step, each computing acc += c[k]*(x[n-k]+x[n-(TAPS-1-k)]).
- The pre-add is DATA_WIDTH+1 bits.
- The accumulator is DATA_WIDTH+1+COEF_WIDTH+$clog2(TAPS/2) bits (32 at defaults).
- acc clears on entry to MAC.
REQ-016 ROUND SHALL compute (acc + 2^13) >>> 14 as an arithmetic shift.
REQ-017 OUT SHALL register the DATA_WIDTH-bit result into data_out and pulse data_valid for exactly one cycle.
REQ-018 Latency: an edge detected at clk edge N SHALL produce data_valid at edge N+3+TAPS/2 (N+11 at defaults).
REQ-019 data_out SHALL hold its value between data_valid pulses.
REQ-020 An edge detected while the state is not IDLE SHALL drop that sample, leave the FSM and delay line untouched, and set overrun, which stays high until reset.
REQ-021 An edge detected in the same cycle the FSM returns to IDLE (the OUT -> IDLE transition) SHALL also be treated as an overrun; only edges seen with state == IDLE are accepted.

Reset
REQ-022 When reset is asserted, the block SHALL asynchronously clear:
- state to IDLE;
- data_out, data_valid, busy and overrun to 0;
- wr_ptr, tap_cnt, acc and data_clk_q to 0;
- every delay-line entry to 0.
REQ-023 Reset asserted mid-MAC SHALL abort the computation with no data_valid pulse, and the first edge after release SHALL be accepted normally.

Configuration
REQ-024 With CIC_COMP_SATURATE_EN defined, ROUND SHALL clamp its result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-025 With CIC_COMP_SATURATE_EN undefined, ROUND SHALL truncate to the DATA_WIDTH LSBs (two's-complement wrap).

Structure
REQ-026 Package cic_pkg SHALL hold the following, and the block SHALL import it:
- the coefficient array CIC_COMP_COEFS of TAPS/2 unique taps, with full-filter sum = 16384 (unity DC gain) and at least one negative tap;
- the COEF_FRAC = 14 constant;
- the s_sample_t and s_acc_t typedefs.
REQ-027 The pre-add, multiply and accumulate datapath SHALL be one sub-module, cic_comp_mac, with ports clk, reset, clear, en, a, b, coef and acc.

Verification
REQ-028 Impulse: one sample of 1000, then zeros, with edges every 16 clk -> the sequence of TAPS outputs equals round(1000*c_k/16384) in tap order, each pulse at N+11.
REQ-029 DC: constant 2047 for 40 edges -> from the 16th output onward, data_out = 2047 exactly.
REQ-030 Saturation: 16 samples of +/-2047 sign-matched to the taps -> data_out = 2047 with CIC_COMP_SATURATE_EN, and the 12-bit wrapped value without it.
REQ-031 Overrun: two edges 6 clk apart -> the second sample is ignored, overrun = 1, and only one data_valid pulse occurs.
REQ-032 Reset mid-MAC: assert reset at N+5 -> no data_valid, all outputs 0; a later impulse test gives the REQ-028 result.
REQ-033 Wrap: 40 ramp samples 0..39 -> each output matches the golden model across wr_ptr wrap at 15 -> 0.
